// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M multiply/divide sequencer.
package muldiv_pkg;

  localparam int MD_XLEN = 32;
  localparam int MD_ITER = 32;

  localparam logic [2:0] MD_OP_MUL    = 3'b000;
  localparam logic [2:0] MD_OP_MULH   = 3'b001;
  localparam logic [2:0] MD_OP_MULHSU = 3'b010;
  localparam logic [2:0] MD_OP_MULHU  = 3'b011;
  localparam logic [2:0] MD_OP_DIV    = 3'b100;
  localparam logic [2:0] MD_OP_DIVU   = 3'b101;
  localparam logic [2:0] MD_OP_REM    = 3'b110;
  localparam logic [2:0] MD_OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    MD_ST_IDLE = 2'd0,
    MD_ST_PREP = 2'd1,
    MD_ST_CALC = 2'd2,
    MD_ST_FIX  = 2'd3
  } md_state_e;

  // Two's-complement negate when neg is set (magnitude / sign restore).
  function automatic logic [MD_XLEN-1:0] md_cneg(input logic [MD_XLEN-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply or restoring divide around a shared 33-bit add/subtract.
module muldiv_step
  import muldiv_pkg::*;
(
  input  logic               mode_div_i,
  input  logic [MD_XLEN-1:0] hi_i,
  input  logic [MD_XLEN-1:0] lo_i,
  input  logic [MD_XLEN-1:0] opnd_i,
  output logic [MD_XLEN-1:0] hi_o,
  output logic [MD_XLEN-1:0] lo_o,
  output logic [MD_XLEN:0]   sum_o,
  output logic               q_o
);

  logic [MD_XLEN:0] opa;
  logic [MD_XLEN:0] opb;
  logic [MD_XLEN:0] keep;

  always_comb begin
    opb   = {1'b0, opnd_i};
    opa   = mode_div_i ? {hi_i, lo_i[MD_XLEN-1]} : {1'b0, hi_i};
    sum_o = mode_div_i ? (opa - opb) : (opa + opb);
    q_o   = 1'b0;
    keep  = '0;
    hi_o  = hi_i;
    lo_o  = lo_i;
    if (mode_div_i) begin
      // A set remainder MSB means the shifted value already exceeds any 32-bit divisor.
      q_o  = hi_i[MD_XLEN-1] | ~sum_o[MD_XLEN];
      hi_o = q_o ? sum_o[MD_XLEN-1:0] : opa[MD_XLEN-1:0];
      lo_o = {lo_i[MD_XLEN-2:0], q_o};
    end else begin
      keep = lo_i[0] ? sum_o : {1'b0, hi_i};
      hi_o = keep[MD_XLEN:1];
      lo_o = {keep[0], lo_i[MD_XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// RV32M multi-cycle multiply/divide sequencer: FSM, counter, sign handling, result registers.
// MULDIV_DIV_EN enables the divider; without it divide opcodes complete as illegal.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int XLEN = MD_XLEN
)
(
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] in_0,
  input  logic [XLEN-1:0] in_1,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] out,
  output logic            dz,
  output logic            illegal
);

  md_state_e       state_q, state_d;
  logic [2:0]      op_q;
  logic [XLEN-1:0] in0_q, in1_q, opnd_q, hi_q, lo_q, out_q;
  logic [5:0]      cnt_q;
  logic            neg_q, dz_q, ill_q, done_q, dz_out_q, ill_out_q;

  logic op_div, op_ill;
  logic sa_en, sb_en, sa, sb, div_zero;
  logic latch_en, prep_en, calc_en, fix_en;
  logic [XLEN-1:0]   step_hi, step_lo, result;
  logic [XLEN:0]     step_sum;
  logic              step_q;
  logic              unused_step;
  logic [2*XLEN-1:0] prod, prod_fix;

`ifdef MULDIV_DIV_EN
  assign op_div = op_q[2];
  assign op_ill = 1'b0;
`else
  assign op_div = 1'b0;
  assign op_ill = op_q[2];
`endif

  assign sa_en    = op_div ? ~op_q[0] : (op_q[1:0] != 2'b11);
  assign sb_en    = op_div ? ~op_q[0] : ~op_q[1];
  assign sa       = sa_en & in0_q[XLEN-1];
  assign sb       = sb_en & in1_q[XLEN-1];
  assign div_zero = op_div & (in1_q == '0);

  muldiv_step u_step (
    .mode_div_i (op_div),
    .hi_i       (hi_q),
    .lo_i       (lo_q),
    .opnd_i     (opnd_q),
    .hi_o       (step_hi),
    .lo_o       (step_lo),
    .sum_o      (step_sum),
    .q_o        (step_q)
  );
  assign unused_step = ^{step_sum, step_q};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= MD_ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      MD_ST_IDLE: if (start) state_d = MD_ST_PREP;
      MD_ST_PREP: begin
        if (flush)                   state_d = MD_ST_IDLE;
        else if (op_ill || div_zero) state_d = MD_ST_FIX;
        else                         state_d = MD_ST_CALC;
      end
      MD_ST_CALC: begin
        if (flush)                            state_d = MD_ST_IDLE;
        else if (cnt_q == 6'(MD_ITER - 1))    state_d = MD_ST_FIX;
      end
      MD_ST_FIX:  state_d = MD_ST_IDLE;
      default:    state_d = MD_ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q != MD_ST_IDLE);
    latch_en = (state_q == MD_ST_IDLE) && start;
    prep_en  = (state_q == MD_ST_PREP) && !flush;
    calc_en  = (state_q == MD_ST_CALC) && !flush;
    fix_en   = (state_q == MD_ST_FIX)  && !flush;
  end

  assign prod     = {hi_q, lo_q};
  assign prod_fix = neg_q ? (~prod + 1'b1) : prod;

  always_comb begin
    result = '0;
    if (ill_q)                 result = '0;
    else if (dz_q)             result = op_q[1] ? in0_q : '1;
    else if (op_div)           result = md_cneg(op_q[1] ? hi_q : lo_q, neg_q);
    else if (op_q[1:0] == 2'b00) result = prod_fix[XLEN-1:0];
    else                       result = prod_fix[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q      <= '0;
      in0_q     <= '0;
      in1_q     <= '0;
      opnd_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      dz_q      <= 1'b0;
      ill_q     <= 1'b0;
      out_q     <= '0;
      done_q    <= 1'b0;
      dz_out_q  <= 1'b0;
      ill_out_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (latch_en) begin
        op_q  <= op;
        in0_q <= in_0;
        in1_q <= in_1;
      end
      if (prep_en) begin
        hi_q   <= '0;
        lo_q   <= op_div ? md_cneg(in0_q, sa) : md_cneg(in1_q, sb);
        opnd_q <= op_div ? md_cneg(in1_q, sb) : md_cneg(in0_q, sa);
        // Remainder takes the dividend's sign; quotient and product take the XOR.
        neg_q  <= (op_div && op_q[1]) ? sa : (sa ^ sb);
        dz_q   <= div_zero;
        ill_q  <= op_ill;
        cnt_q  <= '0;
      end
      if (calc_en) begin
        hi_q  <= step_hi;
        lo_q  <= step_lo;
        cnt_q <= cnt_q + 6'd1;
      end
      if (fix_en) begin
        out_q     <= result;
        done_q    <= 1'b1;
        dz_out_q  <= dz_q;
        ill_out_q <= ill_q;
      end
    end
  end

  assign done    = done_q;
  assign out     = out_q;
  assign dz      = dz_out_q;
  assign illegal = ill_out_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed plan cases plus randomized ops against an arithmetic model.
module tb_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        reset, start, flush;
  logic [2:0]  op;
  logic [31:0] in_0, in_1;
  logic        busy, done, dz, illegal;
  logic [31:0] dut_out;

  int checks = 0;
  int errors = 0;

  logic [2:0]  last_op;
  logic [31:0] last_a, last_b;

  muldiv_ctrl dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .in_0    (in_0),
    .in_1    (in_1),
    .flush   (flush),
    .busy    (busy),
    .done    (done),
    .out     (dut_out),
    .dz      (dz),
    .illegal (illegal)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model_mul(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = (o == 3'b011) ? {32'b0, a} : {{32{a[31]}}, a};
    eb = (o == 3'b010 || o == 3'b011) ? {32'b0, b} : {{32{b[31]}}, b};
    p  = ea * eb;
    return (o == 3'b000) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [31:0] model_div(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint x, y, r;
    logic [63:0] t;
    if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
    if (o[0]) begin x = longint'({32'b0, a}); y = longint'({32'b0, b}); end
    else begin x = longint'($signed(a)); y = longint'($signed(b)); end
    r = o[1] ? (x % y) : (x / y);
    t = r;
    return t[31:0];
  endfunction

  function automatic logic [31:0] rnd32();
    logic [31:0] corners [5];
    corners = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    if ($urandom_range(0, 5) == 0) return corners[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o; in_0 = a; in_1 = b; start = 1'b1;
    last_op = o; last_a = a; last_b = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output logic [31:0] r, output logic z, output logic il, output int lat, output int bc);
    bit got = 0;
    lat = 0; bc = 0;
    while (lat < 100 && !got) begin
      if (busy) bc++;
      @(posedge clk); #1;
      lat++;
      got = done;
    end
    r = dut_out; z = dz; il = illegal;
    $display("txn op=%0d a=%h b=%h -> out=%h dz=%b ill=%b lat=%0d", last_op, last_a, last_b, r, z, il, lat);
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; flush = 1'b0; op = '0; in_0 = '0; in_1 = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, dz, illegal, dut_out} !== 36'h0) begin
      errors++; $display("FAIL reset_state: got busy=%b done=%b dz=%b ill=%b out=%h required all 0", busy, done, dz, illegal, dut_out);
    end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_mul_directed();
    logic [2:0]  ops [4] = '{3'b000, 3'b001, 3'b011, 3'b010};
    logic [31:0] as  [4] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] bs  [4] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] ex  [4] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
    logic [31:0] r; logic z, il; int lat, bc;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); issue(ops[i], as[i], bs[i]);
      wait_done(r, z, il, lat, bc);
      checks++;
      if (r !== ex[i]) begin errors++; $display("FAIL mul_dir_out[%0d]: got %h required %h", i, r, ex[i]); end
      checks++;
      if (lat !== 34 || bc !== 34) begin errors++; $display("FAIL mul_dir_timing[%0d]: got lat=%0d busy=%0d required 34/34", i, lat, bc); end
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL done_pulse_width: got done=%b busy=%b required 0/0", done, busy); end
  endtask

  task automatic test_mul_random();
    logic [31:0] a, b, r, e; logic [2:0] o; logic z, il; int lat, bc;
    for (int i = 0; i < 24; i++) begin
      o = 3'($urandom_range(0, 3)); a = rnd32(); b = rnd32();
      e = model_mul(o, a, b);
      @(negedge clk); issue(o, a, b);
      wait_done(r, z, il, lat, bc);
      checks++;
      if ({r, z, il} !== {e, 2'b00} || lat !== 34) begin
        errors++; $display("FAIL mul_rand[%0d] op=%0d a=%h b=%h: got out=%h dz=%b ill=%b lat=%0d required out=%h dz=0 ill=0 lat=34", i, o, a, b, r, z, il, lat, e);
      end
    end
  endtask

`ifdef MULDIV_DIV_EN
  task automatic test_div();
    logic [2:0]  ops [6] = '{3'b100, 3'b110, 3'b101, 3'b111, 3'b100, 3'b110};
    logic [31:0] as  [6] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] bs  [6] = '{32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] ex  [6] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
    logic [31:0] a, b, r, e; logic [2:0] o; logic z, il; int lat, bc, el;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); issue(ops[i], as[i], bs[i]);
      wait_done(r, z, il, lat, bc);
      el = (bs[i] == 0) ? 2 : 34;
      checks++;
      if ({r, z, il} !== {ex[i], (bs[i] == 0), 1'b0} || lat !== el || bc !== el) begin
        errors++; $display("FAIL div_dir[%0d]: got out=%h dz=%b ill=%b lat=%0d busy=%0d required out=%h lat=%0d", i, r, z, il, lat, bc, ex[i], el);
      end
    end
    for (int i = 0; i < 24; i++) begin
      o = 3'($urandom_range(4, 7)); a = rnd32();
      b = ($urandom_range(0, 5) == 0) ? 32'd0 : rnd32();
      e = model_div(o, a, b);
      @(negedge clk); issue(o, a, b);
      wait_done(r, z, il, lat, bc);
      checks++;
      if ({r, z, il} !== {e, (b == 0), 1'b0} || lat !== ((b == 0) ? 2 : 34)) begin
        errors++; $display("FAIL div_rand[%0d] op=%0d a=%h b=%h: got out=%h dz=%b lat=%0d required %h", i, o, a, b, r, z, lat, e);
      end
    end
  endtask
`else
  task automatic test_illegal();
    logic [31:0] r; logic [2:0] o; logic z, il; int lat, bc;
    for (int i = 0; i < 4; i++) begin
      o = 3'(4 + i);
      @(negedge clk); issue(o, rnd32(), rnd32());
      wait_done(r, z, il, lat, bc);
      checks++;
      if ({r, z, il} !== {32'h0, 1'b0, 1'b1} || lat !== 2) begin
        errors++; $display("FAIL illegal[%0d]: got out=%h dz=%b ill=%b lat=%0d required 0/0/1 lat=2", i, r, z, il, lat);
      end
    end
  endtask
`endif

  task automatic test_start_ignored();
    logic [31:0] r; logic z, il; int lat, bc; bit seen = 0;
    @(negedge clk); issue(3'b000, 32'd7, 32'hFFFF_FFFD);
    repeat (4) begin @(posedge clk); #1; end
    op = 3'b011; in_0 = 32'h1234_5678; in_1 = 32'h9ABC_DEF0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    wait_done(r, z, il, lat, bc);
    checks++;
    if (r !== 32'hFFFF_FFEB || lat !== 29) begin errors++; $display("FAIL start_ignored: got out=%h lat=%0d required FFFFFFEB lat=29", r, lat); end
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (busy || done) seen = 1;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL start_not_queued: got activity=1 required 0"); end
  endtask

  task automatic test_flush();
    logic [31:0] r, keep; logic z, il; int lat, bc; bit seen;
    keep = model_mul(3'b001, 32'h1234_5678, 32'hFEDC_BA98);
    @(negedge clk); issue(3'b001, 32'h1234_5678, 32'hFEDC_BA98);
    wait_done(r, z, il, lat, bc);
    checks++;
    if (r !== keep) begin errors++; $display("FAIL flush_setup: got %h required %h", r, keep); end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); issue(3'b000, rnd32(), rnd32());
      repeat (k == 0 ? 8 : 33) begin @(posedge clk); #1; end
      flush = 1'b1;
      @(posedge clk); #1; flush = 1'b0;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL flush_idle[%0d]: got busy=%b done=%b required 0/0", k, busy, done); end
      seen = 0;
      for (int i = 0; i < 40; i++) begin @(posedge clk); #1; if (done) seen = 1; end
      checks++;
      if (seen !== 1'b0 || dut_out !== keep) begin errors++; $display("FAIL flush_no_done[%0d]: got done_seen=%b out=%h required 0 out=%h", k, seen, dut_out, keep); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a [3], b [3], r; logic [2:0] o [3]; logic z, il; int lat, bc;
    for (int i = 0; i < 3; i++) begin o[i] = 3'($urandom_range(0, 3)); a[i] = rnd32(); b[i] = rnd32(); end
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      issue(o[i], a[i], b[i]);
      wait_done(r, z, il, lat, bc);
      checks++;
      if (r !== model_mul(o[i], a[i], b[i]) || lat !== 34) begin
        errors++; $display("FAIL back_to_back[%0d]: got out=%h lat=%0d required %h lat=34", i, r, lat, model_mul(o[i], a[i], b[i]));
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r; logic z, il; int lat, bc;
    @(negedge clk); issue(3'b000, 32'd7, 32'hFFFF_FFFD);
    repeat (19) begin @(posedge clk); #1; end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({busy, done, dz, illegal, dut_out} !== 36'h0) begin
      errors++; $display("FAIL reset_mid: got busy=%b done=%b dz=%b ill=%b out=%h required all 0", busy, done, dz, illegal, dut_out);
    end
    @(negedge clk); reset = 1'b0;
    @(negedge clk); issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(r, z, il, lat, bc);
    checks++;
    if (r !== 32'hFFFF_FFFE || lat !== 34) begin errors++; $display("FAIL after_reset: got out=%h lat=%0d required FFFFFFFE lat=34", r, lat); end
  endtask

  initial begin
    test_reset();
    test_mul_directed();
`ifdef MULDIV_DIV_EN
    test_div();
`else
    test_illegal();
`endif
    test_mul_random();
    test_start_ignored();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
